// File: rtl/ssd_pkg.sv
// Shared seven-segment constants. The segment driver and the capture receiver both
// import this package, so the encode and decode tables always use the same glyphs.
package ssd_pkg;

    localparam int NUM_DIGITS_DEF = 8;

    // Cathodes are active-low. Bit order is [6]=g, [5]=f, [4]=e, [3]=d, [2]=c, [1]=b, [0]=a.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0011000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/ssd_seg_decode.sv
// Combinational reverse lookup: maps a cathode pattern to its hex value.
// It also reports whether the pattern is a known glyph or the all-off pattern.
module ssd_seg_decode
    import ssd_pkg::*;
(
    input  logic [6:0] cc_i,
    output logic       match_o,
    output logic       blank_o,
    output logic [3:0] value_o
);

    always_comb begin
        match_o = 1'b1;
        blank_o = 1'b0;
        value_o = 4'h0;
        case (cc_i)
            SEG_0:     value_o = 4'h0;
            SEG_1:     value_o = 4'h1;
            SEG_2:     value_o = 4'h2;
            SEG_3:     value_o = 4'h3;
            SEG_4:     value_o = 4'h4;
            SEG_5:     value_o = 4'h5;
            SEG_6:     value_o = 4'h6;
            SEG_7:     value_o = 4'h7;
            SEG_8:     value_o = 4'h8;
            SEG_9:     value_o = 4'h9;
            SEG_A:     value_o = 4'hA;
            SEG_B:     value_o = 4'hB;
            SEG_C:     value_o = 4'hC;
            SEG_D:     value_o = 4'hD;
            SEG_E:     value_o = 4'hE;
            SEG_F:     value_o = 4'hF;
            SEG_BLANK: begin
                match_o = 1'b0;
                blank_o = 1'b1;
            end
            default:   match_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/ssd_capture.sv
// Receiver for a multiplexed seven-segment bus. It filters the sampled lines for
// stability, then decodes each accepted pattern into a per-digit hex nibble and status flags.
module ssd_capture
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS    = NUM_DIGITS_DEF,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                      ssd_capture_port_clk,
    input  logic                      ssd_capture_port_rst,
    input  logic [NUM_DIGITS-1:0]     ssd_capture_port_an,
    input  logic [6:0]                ssd_capture_port_cc,
    input  logic                      ssd_capture_port_dp,
    output logic [4*NUM_DIGITS-1:0]   ssd_capture_port_digits,
    output logic [NUM_DIGITS-1:0]     ssd_capture_port_dps,
    output logic [NUM_DIGITS-1:0]     ssd_capture_port_blank,
    output logic [NUM_DIGITS-1:0]     ssd_capture_port_err,
    output logic                      ssd_capture_port_upd,
    output logic                      ssd_capture_port_frame,
    output logic                      ssd_capture_port_multi
);

    localparam int SW = NUM_DIGITS + 8;
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

    logic [SW-1:0]           in_vec;
    logic [SW-1:0]           sample_q;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    acc_q, acc_d;
    logic [NUM_DIGITS-1:0]   s_an, anl, sel, seen_q, seen_d, seen_or;
    logic [6:0]              s_cc;
    logic                    s_dp;
    logic                    one_hot, many;
    logic                    dec_match, dec_blank;
    logic [3:0]              dec_value;

    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   dps_q, dps_d, blank_q, blank_d, err_q, err_d;
    logic                    upd_q, upd_d, frame_q, frame_d, multi_q, multi_d;

    assign in_vec = {ssd_capture_port_an, ssd_capture_port_cc, ssd_capture_port_dp};
    assign s_an   = sample_q[SW-1 -: NUM_DIGITS];
    assign s_cc   = sample_q[7:1];
    assign s_dp   = sample_q[0];

    // The accept pulse is registered, so the slot update happens one edge after the
    // counter saturates. sample_q still holds the accepted pattern on that edge.
    always_comb begin
        cnt_d = '0;
        if (in_vec == sample_q) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        end
        acc_d = (cnt_d == CNT_MAX) && (cnt_q != CNT_MAX);
    end

    assign anl     = ~s_an;
    assign one_hot = (anl != '0) && ((anl & (anl - NUM_DIGITS'(1))) == '0);
    assign many    = (anl != '0) && !one_hot;

    ssd_seg_decode u_dec (
        .cc_i    (s_cc),
        .match_o (dec_match),
        .blank_o (dec_blank),
        .value_o (dec_value)
    );

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_sel
        assign sel[gi] = acc_q && one_hot && anl[gi];
    end

    always_comb begin
        digits_d = digits_q;
        dps_d    = dps_q;
        blank_d  = blank_q;
        err_d    = err_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel[i]) begin
                dps_d[i]   = ~s_dp;
                blank_d[i] = dec_blank;
                err_d[i]   = !dec_match && !dec_blank;
                if (dec_match) begin
                    digits_d[4*i +: 4] = dec_value;
                end
            end
        end
        upd_d   = acc_q && one_hot;
        seen_or = seen_q | sel;
        frame_d = upd_d && (&seen_or);
        seen_d  = frame_d ? '0 : seen_or;
        multi_d = multi_q || (acc_q && many);
    end

    always_ff @(posedge ssd_capture_port_clk) begin
        if (ssd_capture_port_rst) begin
            sample_q <= '1;
            cnt_q    <= '0;
            acc_q    <= 1'b0;
            seen_q   <= '0;
            digits_q <= '0;
            dps_q    <= '0;
            blank_q  <= '1;
            err_q    <= '0;
            upd_q    <= 1'b0;
            frame_q  <= 1'b0;
            multi_q  <= 1'b0;
        end else begin
            sample_q <= in_vec;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            seen_q   <= seen_d;
            digits_q <= digits_d;
            dps_q    <= dps_d;
            blank_q  <= blank_d;
            err_q    <= err_d;
            upd_q    <= upd_d;
            frame_q  <= frame_d;
            multi_q  <= multi_d;
        end
    end

    assign ssd_capture_port_digits = digits_q;
    assign ssd_capture_port_dps    = dps_q;
    assign ssd_capture_port_blank  = blank_q;
    assign ssd_capture_port_err    = err_q;
    assign ssd_capture_port_upd    = upd_q;
    assign ssd_capture_port_frame  = frame_q;
    assign ssd_capture_port_multi  = multi_q;

endmodule

// File: tb/tb_ssd_capture.sv
// Directed self-checking bench for ssd_capture with 8 digits and STABLE_CYCLES = 4.
// Inputs change on falling edges; outputs are sampled on falling edges.
module tb_ssd_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  an;
    logic [6:0]  cc;
    logic        dp;
    logic [31:0] digits;
    logic [7:0]  dps, blank, err;
    logic        upd, frame, multi;

    int checks = 0;
    int passed = 0;
    logic [6:0] glyph [16];

    always #5 clk = ~clk;

    ssd_capture #(.NUM_DIGITS(8), .STABLE_CYCLES(4)) dut (
        .ssd_capture_port_clk    (clk),
        .ssd_capture_port_rst    (rst),
        .ssd_capture_port_an     (an),
        .ssd_capture_port_cc     (cc),
        .ssd_capture_port_dp     (dp),
        .ssd_capture_port_digits (digits),
        .ssd_capture_port_dps    (dps),
        .ssd_capture_port_blank  (blank),
        .ssd_capture_port_err    (err),
        .ssd_capture_port_upd    (upd),
        .ssd_capture_port_frame  (frame),
        .ssd_capture_port_multi  (multi)
    );

    // Apply a pattern at a falling edge and hold it for n rising edges, observing each one.
    task automatic hold(input logic [7:0] a, input logic [6:0] c, input logic d, input int n,
                        output int nupd, output int nframe, output int nboth, output int upd_at);
        an = a; cc = c; dp = d;
        nupd = 0; nframe = 0; nboth = 0; upd_at = -1;
        for (int e = 0; e < n; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (upd) begin
                nupd++;
                if (upd_at < 0) upd_at = e;
            end
            if (frame) nframe++;
            if (frame && upd) nboth++;
        end
    endtask

    task automatic test_reset();
        int nu, nf, nb, ua;
        rst = 1'b1; an = 8'hFF; cc = 7'h7F; dp = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (digits !== 32'h0 || blank !== 8'hFF || err !== 8'h00 || dps !== 8'h00 ||
            upd !== 1'b0 || frame !== 1'b0 || multi !== 1'b0)
            $display("FAIL reset_state: digits=%h blank=%h err=%h dps=%h upd=%b frame=%b multi=%b, required 00000000 ff 00 00 0 0 0",
                     digits, blank, err, dps, upd, frame, multi);
        else passed++;
        rst = 1'b0;
        hold(8'hFF, 7'h7F, 1'b1, 20, nu, nf, nb, ua);
        checks++;
        if (nu !== 0 || nf !== 0 || multi !== 1'b0)
            $display("FAIL idle_quiet: upd=%0d frame=%0d multi=%b, required 0 0 0", nu, nf, multi);
        else passed++;
        checks++;
        if (digits !== 32'h0 || blank !== 8'hFF || err !== 8'h00)
            $display("FAIL idle_state: digits=%h blank=%h err=%h, required 00000000 ff 00", digits, blank, err);
        else passed++;
        $display("test_reset done");
    endtask

    task automatic test_latency();
        int nu, nf, nb, ua;
        hold(8'hFE, 7'b0100100, 1'b0, 9, nu, nf, nb, ua);
        checks++;
        if (ua !== 5 || nu !== 1)
            $display("FAIL latency: first upd at edge k+%0d, pulses=%0d, required k+5 and 1", ua, nu);
        else passed++;
        checks++;
        if (digits[3:0] !== 4'h2 || dps[0] !== 1'b1 || blank[0] !== 1'b0)
            $display("FAIL latency_value: digit0=%h dp0=%b blank0=%b, required 2 1 0", digits[3:0], dps[0], blank[0]);
        else passed++;
        $display("test_latency done: upd at k+%0d", ua);
    endtask

    task automatic test_scan();
        int nu, nf, nb, ua;
        int tu = 0, tf = 0, tb = 0, fd = -1;
        logic [7:0] a;
        for (int d = 0; d < 8; d++) begin
            a = ~(8'h01 << d);
            hold(a, glyph[d], 1'b1, 8, nu, nf, nb, ua);
            tu += nu; tf += nf; tb += nb;
            if (nf > 0) fd = d;
        end
        checks++;
        if (digits !== 32'h76543210)
            $display("FAIL scan_digits: got %h, required 76543210", digits);
        else passed++;
        checks++;
        if (tu !== 8) $display("FAIL scan_upd_count: got %0d, required 8", tu);
        else passed++;
        checks++;
        if (tf !== 1 || tb !== 1 || fd !== 7)
            $display("FAIL scan_frame: frames=%0d with_upd=%0d on digit %0d, required 1 1 7", tf, tb, fd);
        else passed++;
        checks++;
        if (dps !== 8'h00 || blank !== 8'h00 || err !== 8'h00)
            $display("FAIL scan_flags: dps=%h blank=%h err=%h, required 00 00 00", dps, blank, err);
        else passed++;
        $display("test_scan done: digits=%h", digits);
    endtask

    task automatic test_short_pulse();
        int nu, nf, nb, ua;
        hold(8'hFD, glyph[10], 1'b1, 8, nu, nf, nb, ua);
        checks++;
        if (digits[7:4] !== 4'hA || nu !== 1)
            $display("FAIL preset_digit1: got %h upd=%0d, required a 1", digits[7:4], nu);
        else passed++;
        hold(8'hFD, 7'b0110000, 1'b1, 3, nu, nf, nb, ua);
        checks++;
        if (nu !== 0 || digits[7:4] !== 4'hA)
            $display("FAIL short_reject: upd=%0d digit1=%h, required 0 a", nu, digits[7:4]);
        else passed++;
        hold(8'hFD, 7'b1111001, 1'b1, 6, nu, nf, nb, ua);
        checks++;
        if (nu !== 1 || digits[7:4] !== 4'h1)
            $display("FAIL stable_accept: upd=%0d digit1=%h, required 1 1", nu, digits[7:4]);
        else passed++;
        $display("test_short_pulse done");
    endtask

    task automatic test_err_blank_multi();
        int nu, nf, nb, ua;
        hold(8'hF7, 7'b1010101, 1'b1, 8, nu, nf, nb, ua);
        checks++;
        if (err[3] !== 1'b1 || blank[3] !== 1'b0 || digits !== 32'h76543210 || nu !== 1)
            $display("FAIL illegal_glyph: err3=%b blank3=%b digits=%h upd=%0d, required 1 0 76543210 1",
                     err[3], blank[3], digits, nu);
        else passed++;
        hold(8'hF7, 7'h7F, 1'b1, 8, nu, nf, nb, ua);
        checks++;
        if (err[3] !== 1'b0 || blank[3] !== 1'b1 || digits !== 32'h76543210)
            $display("FAIL blank_glyph: err3=%b blank3=%b digits=%h, required 0 1 76543210", err[3], blank[3], digits);
        else passed++;
        hold(8'b11110011, glyph[8], 1'b0, 8, nu, nf, nb, ua);
        checks++;
        if (multi !== 1'b1 || nu !== 0 || digits !== 32'h76543210)
            $display("FAIL multi_anode: multi=%b upd=%0d digits=%h, required 1 0 76543210", multi, nu, digits);
        else passed++;
        hold(8'hFF, 7'h7F, 1'b1, 8, nu, nf, nb, ua);
        checks++;
        if (multi !== 1'b1) $display("FAIL multi_sticky: got %b, required 1", multi);
        else passed++;
        $display("test_err_blank_multi done");
    endtask

    task automatic test_reset_midcount();
        int nu, nf, nb, ua;
        int bad = 0;
        hold(8'hFE, glyph[5], 1'b0, 3, nu, nf, nb, ua);
        rst = 1'b1;
        for (int e = 0; e < 2; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (upd) bad++;
        end
        checks++;
        if (nu + bad !== 0) $display("FAIL midcount_no_upd: got %0d pulses, required 0", nu + bad);
        else passed++;
        checks++;
        if (digits !== 32'h0 || blank !== 8'hFF || err !== 8'h00 || dps !== 8'h00 ||
            multi !== 1'b0 || frame !== 1'b0)
            $display("FAIL midcount_reset_state: digits=%h blank=%h err=%h dps=%h multi=%b frame=%b, required 00000000 ff 00 00 0 0",
                     digits, blank, err, dps, multi, frame);
        else passed++;
        rst = 1'b0;
        hold(8'hFE, glyph[5], 1'b0, 8, nu, nf, nb, ua);
        checks++;
        if (nu !== 1 || ua !== 5 || digits !== 32'h00000005 || dps !== 8'h01 || blank !== 8'hFE)
            $display("FAIL resume: upd=%0d at k+%0d digits=%h dps=%h blank=%h, required 1 at k+5 00000005 01 fe",
                     nu, ua, digits, dps, blank);
        else passed++;
        $display("test_reset_midcount done");
    endtask

    initial begin
        glyph[0]  = 7'b1000000; glyph[1]  = 7'b1111001; glyph[2]  = 7'b0100100; glyph[3]  = 7'b0110000;
        glyph[4]  = 7'b0011001; glyph[5]  = 7'b0010010; glyph[6]  = 7'b0000010; glyph[7]  = 7'b1111000;
        glyph[8]  = 7'b0000000; glyph[9]  = 7'b0011000; glyph[10] = 7'b0001000; glyph[11] = 7'b0000011;
        glyph[12] = 7'b1000110; glyph[13] = 7'b0100001; glyph[14] = 7'b0000110; glyph[15] = 7'b0001110;
        rst = 1'b1; an = 8'hFF; cc = 7'h7F; dp = 1'b1;
        @(negedge clk);
        test_reset();
        test_latency();
        test_scan();
        test_short_pulse();
        test_err_blank_multi();
        test_reset_midcount();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
